trunc_pipe: RTL and testbench
=============================

Name: trunc_pipe

Overview:
Pipelined, multi-lane successor to the combinational truncator.
- Per lane, it masks an N-bit signal using the priority position of the lowest set bit of a truncator word.
- A 2-bit mode selects the masking variant.
- Results pass through a 2-stage valid/ready pipeline and carry a per-lane dropped-bit count.
- A saturating statistics counter tracks how many beats lost any bits.
- It sits between a quantiser front-end and downstream packers that need backpressure.

Parameters:
N, 5, bits per lane signal/truncator
LANES, 2, independent lanes processed per beat
STAT_W, 16, width of saturating statistics counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_signal  in  N*LANES  lane k at bits [k*N +: N]
in_truncator  in  N*LANES  lane k at bits [k*N +: N]
in_mode  in  2  masking mode for the whole beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  N*LANES  truncated lanes, same packing
out_dropped  out  CW*LANES  per-lane count of signal bits removed; CW = $clog2(N+1)
out_any_drop  out  1  OR over lanes of (dropped != 0)
stat_clr  in  1  synchronous clear of stat_count
stat_count  out  STAT_W  saturating count of output beats with out_any_drop=1

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state: both stage valids 0, out_valid=0, out_data=0, out_dropped=0, out_any_drop=0, stat_count=0. in_ready=1 once rst deasserts.
- Mask per lane, where t = truncator and mask_lo[i] = |t[i:0]:
  - mode 00 (keep-below): kept = s & ~mask_lo.
  - mode 01 (keep-below-inclusive): mask_in[0]=0, mask_in[i] = |t[i-1:0]; kept = s & ~mask_in.
  - mode 10 (keep-above): kept = s & mask_lo.
  - mode 11 (passthrough): kept = s.
- Dropped count = popcount(s & ~kept), width CW.
- t == 0 in all modes: mask_lo = mask_in = 0. Mode 00/01 output s with dropped 0. Mode 10 outputs 0 with dropped = popcount(s).
- Pipeline:
  - S1 registers the beat and the computed mask (mode folded in).
  - S2 registers kept, dropped and any_drop; S2 is the output register.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - S2 advances when !out_valid | out_ready.
  - S1 advances when S2 advances.
  - in_ready = !s1_valid | s2_advance. This is combinational from out_ready; no combinational in_valid→out_valid path.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle under continuous out_ready.
- Stall: while out_valid & !out_ready, out_data, out_dropped and out_any_drop hold stable. S1 holds, and at most 2 beats are buffered. No beat is lost or duplicated.
- Bubbles: a stage with no incoming beat clears its valid on advance. Data registers may hold stale values when valid=0.
- stat_count:
  - Increments by 1 on each output handshake (out_valid & out_ready) with out_any_drop=1.
  - Saturates at 2^STAT_W-1.
  - stat_clr has priority over a simultaneous increment; result is 0 that cycle.
- Reset mid-operation: in-flight beats are discarded immediately and asynchronously, and stat_count is cleared.
- LANES=1 and N=1 must elaborate. Lanes are fully independent except for out_any_drop and the shared mode.

Test Plan:
- N=5, LANES=1, mode 00, s=10111, t=00100, out_ready=1 → 2 cycles later out_data=00011, dropped=2, any_drop=1, stat_count=1.
- Same s/t in modes 01/10/11 back-to-back → outputs on consecutive cycles:
  - 01: 00111, dropped 1.
  - 10: 10100, dropped 2.
  - 11: 10111, dropped 0.
- t=00000, s=10111:
  - mode 00 → 10111, dropped 0, any_drop=0, stat_count unchanged.
  - mode 10 → 00000, dropped 4.
- Backpressure: stream 4 beats with out_ready low for 3 cycles → in_ready falls after 2 accepted beats, output holds beat 0 stable, and all 4 emerge in order once out_ready rises.
- LANES=2, one beat with lane0 dropping 0 and lane1 dropping 3 → any_drop=1, out_dropped packs {3,0}. stat_clr asserted on the same handshake → stat_count=0.
- Force stat_count to 2^STAT_W-2, send 3 dropping beats → saturates at 0xFFFF. Assert rst mid-stream → out_valid=0 immediately, stat_count=0, no stale beat emitted after release.

Source files
------------

// File: rtl/trunc_pipe_if.sv
// Beat-level handshake bundle for trunc_pipe: upstream beat, downstream result.
// The master side is the environment, and the slave side is the pipeline.
interface trunc_pipe_if #(
    parameter int N     = 5,
    parameter int LANES = 2
);
    localparam int CW = $clog2(N + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [N*LANES-1:0]    in_signal;
    logic [N*LANES-1:0]    in_truncator;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*LANES-1:0]    out_data;
    logic [CW*LANES-1:0]   out_dropped;
    logic                  out_any_drop;

    modport master (
        output in_valid, in_signal, in_truncator, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_dropped, out_any_drop
    );

    modport slave (
        input  in_valid, in_signal, in_truncator, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_dropped, out_any_drop
    );
endinterface

// File: rtl/trunc_pipe.sv
// Two-stage valid/ready multi-lane truncator: S1 folds the mode into a keep mask,
// and S2 registers the kept bits, the per-lane dropped counts and a drop statistic.
module trunc_pipe #(
    parameter int N      = 5,
    parameter int LANES  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    trunc_pipe_if.slave       bus,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_count
);
    localparam int CW = $clog2(N + 1);

    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [N*LANES-1:0]  keep_mask;
    logic [N*LANES-1:0]  kept_next;
    logic [CW*LANES-1:0] dropped_next;
    logic                any_next;

    logic                s1_valid_reg;
    logic [N*LANES-1:0]  s1_signal_reg;
    logic [N*LANES-1:0]  s1_mask_reg;
    logic                out_valid_reg;
    logic [N*LANES-1:0]  out_data_reg;
    logic [CW*LANES-1:0] out_dropped_reg;
    logic                out_any_reg;
    logic [STAT_W-1:0]   stat_reg;

    logic s2_advance;
    logic in_ready;
    logic accept;

    assign s2_advance = !out_valid_reg || bus.out_ready;
    assign in_ready   = !s1_valid_reg || s2_advance;
    assign accept     = bus.in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [N-1:0] trunc;
            logic [N-1:0] mask_lo;
            logic [N-1:0] mask_in;
            logic [N-1:0] lane_mask;
            logic [N-1:0] lost;

            // mask_lo is a prefix-OR from bit 0 upward; mask_in is the same prefix shifted by one.
            always_comb begin
                trunc   = bus.in_truncator[gi*N +: N];
                mask_lo = trunc;
                for (int i = 1; i < N; i++) begin
                    mask_lo[i] = mask_lo[i-1] | trunc[i];
                end
                mask_in   = mask_lo << 1;
                lane_mask = '1;
                case (bus.in_mode)
                    2'b00:   lane_mask = ~mask_lo;
                    2'b01:   lane_mask = ~mask_in;
                    2'b10:   lane_mask = mask_lo;
                    default: lane_mask = '1;
                endcase
            end

            assign keep_mask[gi*N +: N]     = lane_mask;
            assign lost                     = s1_signal_reg[gi*N +: N] & ~s1_mask_reg[gi*N +: N];
            assign kept_next[gi*N +: N]     = s1_signal_reg[gi*N +: N] & s1_mask_reg[gi*N +: N];
            assign dropped_next[gi*CW +: CW] = popcnt(lost);
        end
    endgenerate

    assign any_next = |dropped_next;

    // S1 may refill while S2 stalls only if it is empty; otherwise it moves with S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_signal_reg <= '0;
            s1_mask_reg   <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= bus.in_valid;
            if (accept) begin
                s1_signal_reg <= bus.in_signal;
                s1_mask_reg   <= keep_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_dropped_reg <= '0;
            out_any_reg     <= 1'b0;
        end else if (s2_advance) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg    <= kept_next;
                out_dropped_reg <= dropped_next;
                out_any_reg     <= any_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reg <= '0;
        end else if (stat_clr) begin
            stat_reg <= '0;
        end else if (out_valid_reg && bus.out_ready && out_any_reg && !(&stat_reg)) begin
            stat_reg <= stat_reg + 1'b1;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_dropped  = out_dropped_reg;
    assign bus.out_any_drop = out_any_reg;
    assign stat_count       = stat_reg;
endmodule

// File: tb/tb_trunc_pipe.sv
// Scoreboard bench for trunc_pipe: the driver queues hand-computed results and a
// negedge monitor pops and compares them on each output handshake.
module tb_trunc_pipe;
    logic        clk;
    logic        rst;
    logic        stat_clr0;
    logic        stat_clr1;
    logic [15:0] stat_count0;
    logic [1:0]  stat_count1;

    trunc_pipe_if #(.N(5), .LANES(2)) bus0 ();
    trunc_pipe_if #(.N(5), .LANES(1)) bus1 ();

    trunc_pipe #(.N(5), .LANES(2), .STAT_W(16)) u0 (
        .clk(clk), .rst(rst), .bus(bus0), .stat_clr(stat_clr0), .stat_count(stat_count0)
    );

    trunc_pipe #(.N(5), .LANES(1), .STAT_W(2)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .stat_clr(stat_clr1), .stat_count(stat_count1)
    );

    typedef struct {
        logic [9:0] d;
        logic [5:0] dr;
        logic       any;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_stat = 16'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Drive a beat on bus0 and push its expected result when it is accepted.
    task automatic send(input logic [9:0] s, input logic [9:0] t, input logic [1:0] m,
                        input logic [9:0] ed, input logic [5:0] edr, input logic ea);
        exp_t e;
        bit   done;
        done = 1'b0;
        bus0.in_valid     = 1'b1;
        bus0.in_signal    = s;
        bus0.in_truncator = t;
        bus0.in_mode      = m;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                e.d = ed; e.dr = edr; e.any = ea;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_accept: got no acceptance required acceptance within 50 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus0.out_valid) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain: got %0d beats pending required 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks stat_count each cycle and the beat on each output handshake.
    initial begin
        exp_t e;
        bit   hs;
        bit   any;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                exp_stat = 16'd0;
            end else begin
                chk("stat_count", 32'(stat_count0), 32'(exp_stat));
                hs  = bus0.out_valid && bus0.out_ready;
                any = 1'b0;
                if (hs) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got data=%h required no beat", bus0.out_data);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", 32'(bus0.out_data), 32'(e.d));
                        chk("out_dropped", 32'(bus0.out_dropped), 32'(e.dr));
                        chk("out_any_drop", 32'(bus0.out_any_drop), 32'(e.any));
                        any = e.any;
                        $display("beat data=%b dropped=%b any=%0b", bus0.out_data,
                                 bus0.out_dropped, bus0.out_any_drop);
                    end
                end
                if (stat_clr0) exp_stat = 16'd0;
                else if (hs && any && exp_stat != 16'hFFFF) exp_stat = exp_stat + 16'd1;
            end
        end
    end

    initial begin
        rst = 1'b1;
        stat_clr0 = 1'b0; stat_clr1 = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_signal = '0; bus0.in_truncator = '0;
        bus0.in_mode = 2'b00; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_signal = '0; bus1.in_truncator = '0;
        bus1.in_mode = 2'b00; bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus0.out_data), 32'd0);
        chk("rst_out_dropped", 32'(bus0.out_dropped), 32'd0);
        chk("rst_any_drop", 32'(bus0.out_any_drop), 32'd0);
        chk("rst_stat", 32'(stat_count0), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(bus0.in_ready), 32'd1);

        // Single lane-0 beat, mode 00.
        send(10'b00000_10111, 10'b00000_00100, 2'b00, 10'b00000_00011, 6'b000_010, 1'b1);
        drain();
        chk("stat_after_first", 32'(stat_count0), 32'd1);

        // Modes 01, 10, 11 back-to-back.
        send(10'b00000_10111, 10'b00000_00100, 2'b01, 10'b00000_00111, 6'b000_001, 1'b1);
        send(10'b00000_10111, 10'b00000_00100, 2'b10, 10'b00000_10100, 6'b000_010, 1'b1);
        send(10'b00000_10111, 10'b00000_00100, 2'b11, 10'b00000_10111, 6'b000_000, 1'b0);
        drain();
        chk("stat_after_modes", 32'(stat_count0), 32'd3);

        // Zero truncator.
        send(10'b00000_10111, 10'b00000_00000, 2'b00, 10'b00000_10111, 6'b000_000, 1'b0);
        drain();
        chk("stat_t0_mode00", 32'(stat_count0), 32'd3);
        send(10'b00000_10111, 10'b00000_00000, 2'b10, 10'b00000_00000, 6'b000_100, 1'b1);
        drain();
        chk("stat_t0_mode10", 32'(stat_count0), 32'd4);

        // Backpressure: two beats fill the pipe, then the output must hold.
        bus0.out_ready = 1'b0;
        send(10'b00000_00001, 10'b0, 2'b11, 10'b00000_00001, 6'b0, 1'b0);
        send(10'b00000_00010, 10'b0, 2'b11, 10'b00000_00010, 6'b0, 1'b0);
        bus0.in_valid = 1'b1; bus0.in_signal = 10'b00000_00100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus0.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus0.out_valid), 32'd1);
            chk("stall_out_data", 32'(bus0.out_data), 32'h001);
            @(posedge clk);
            #1;
        end
        bus0.out_ready = 1'b1;
        send(10'b00000_00100, 10'b0, 2'b11, 10'b00000_00100, 6'b0, 1'b0);
        send(10'b00000_01000, 10'b0, 2'b11, 10'b00000_01000, 6'b0, 1'b0);
        drain();
        chk("stat_after_bp", 32'(stat_count0), 32'd4);

        // Two lanes: lane0 keeps all, lane1 drops 3; stat_clr on the same handshake.
        send(10'b11100_00011, 10'b00100_00100, 2'b00, 10'b00000_00011, 6'b011_000, 1'b1);
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        stat_clr0 = 1'b1;
        @(posedge clk); #1;
        stat_clr0 = 1'b0;
        chk("stat_clr_priority", 32'(stat_count0), 32'd0);
        drain();

        // Reset in mid-stream.
        send(10'b00000_10111, 10'b00000_00100, 2'b00, 10'b00000_00011, 6'b000_010, 1'b1);
        send(10'b00000_10111, 10'b00000_00100, 2'b00, 10'b00000_00011, 6'b000_010, 1'b1);
        send(10'b00000_10111, 10'b00000_00100, 2'b00, 10'b00000_00011, 6'b000_010, 1'b1);
        chk("stat_before_rst", 32'(stat_count0), 32'd1);
        chk("valid_before_rst", 32'(bus0.out_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_async_stat", 32'(stat_count0), 32'd0);
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_beat", 32'(bus0.out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Saturation on a 2-bit counter, single lane.
        bus1.out_ready = 1'b1; bus1.in_valid = 1'b1;
        bus1.in_signal = 5'b10111; bus1.in_truncator = 5'b00100; bus1.in_mode = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        chk("u1_stat_two", 32'(stat_count1), 32'd2);
        chk("u1_out_data", 32'(bus1.out_data), 32'h03);
        chk("u1_out_dropped", 32'(bus1.out_dropped), 32'd2);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        chk("u1_stat_max", 32'(stat_count1), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("u1_stat_saturated", 32'(stat_count1), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
